// File: rtl/rv_alu.sv
// RV32I-style integer ALU for the execute stage. funct3/funct7 are decoded directly.
// The result and the zero/neg/carry/ovf flags are registered, giving one cycle of latency.
module rv_alu #(
  parameter int SIZE = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      f3_i,
  input  logic [6:0]      f7_i,
  input  logic [SIZE-1:0] op1_i,
  input  logic [SIZE-1:0] op2_i,
  output logic [SIZE-1:0] res_o,
  output logic            zero_o,
  output logic            neg_o,
  output logic            carry_o,
  output logic            ovf_o
);
  localparam int SW = $clog2(SIZE);

  logic [SIZE:0]   sum, diff;
  logic [SW-1:0]   shamt;
  logic [SIZE-1:0] res;
  logic            carry, ovf, alt;
  logic            unused;

  // Only f7[5] selects SUB/SRA; the other funct7 bits have no effect.
  assign unused = ^{f7_i[6], f7_i[4:0]};
  assign alt    = f7_i[5];
  assign shamt  = op2_i[SW-1:0];
  assign sum    = {1'b0, op1_i} + {1'b0, op2_i};
  // The top bit of the widened difference is the unsigned borrow.
  assign diff   = {1'b0, op1_i} - {1'b0, op2_i};

  always_comb begin
    res   = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    case (f3_i)
      3'b000: begin
        if (alt) begin
          res   = diff[SIZE-1:0];
          carry = diff[SIZE];
          ovf   = (op1_i[SIZE-1] != op2_i[SIZE-1]) && (res[SIZE-1] != op1_i[SIZE-1]);
        end else begin
          res   = sum[SIZE-1:0];
          carry = sum[SIZE];
          ovf   = (op1_i[SIZE-1] == op2_i[SIZE-1]) && (res[SIZE-1] != op1_i[SIZE-1]);
        end
      end
      3'b001: res = op1_i << shamt;
      3'b010: res = {{(SIZE-1){1'b0}}, $signed(op1_i) < $signed(op2_i)};
      3'b011: res = {{(SIZE-1){1'b0}}, op1_i < op2_i};
      3'b100: res = op1_i ^ op2_i;
      3'b101: res = alt ? SIZE'($signed(op1_i) >>> shamt) : (op1_i >> shamt);
      3'b110: res = op1_i | op2_i;
      3'b111: res = op1_i & op2_i;
      default: res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_o   <= '0;
      zero_o  <= 1'b0;
      neg_o   <= 1'b0;
      carry_o <= 1'b0;
      ovf_o   <= 1'b0;
    end else begin
      res_o   <= res;
      zero_o  <= (res == '0);
      neg_o   <= res[SIZE-1];
      carry_o <= carry;
      ovf_o   <= ovf;
    end
  end
endmodule

// File: tb/tb_rv_alu.sv
// Self-checking bench for rv_alu at SIZE=4.
// Checks directed plan vectors and a random stream against an integer reference model.
module tb_rv_alu;
  localparam int SIZE = 4;

  logic            clk;
  logic            rst;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [SIZE-1:0] op1, op2;
  logic [SIZE-1:0] res;
  logic            zero, neg, carry, ovf;

  int tests = 0;
  int fails = 0;

  rv_alu #(.SIZE(SIZE)) dut (
    .clk(clk), .rst(rst), .f3_i(f3), .f7_i(f7), .op1_i(op1), .op2_i(op2),
    .res_o(res), .zero_o(zero), .neg_o(neg), .carry_o(carry), .ovf_o(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model in plain integer arithmetic; returns {res[3:0], zero, neg, carry, ovf}.
  function automatic logic [7:0] model(input logic [2:0] fn3, input logic [6:0] fn7,
                                       input int a, input int b);
    int as, bs, r, sh, t;
    logic c, v;
    logic [3:0] rr;
    as = (a > 7) ? a - 16 : a;
    bs = (b > 7) ? b - 16 : b;
    sh = b % 4;
    c = 1'b0;
    v = 1'b0;
    r = 0;
    case (fn3)
      3'd0: begin
        if (fn7[5]) begin t = as - bs; r = a - b; c = (a < b); end
        else        begin t = as + bs; r = a + b; c = (a + b > 15); end
        v = (t < -8) || (t > 7);
      end
      3'd1: r = a * (2 ** sh);
      3'd2: r = (as < bs) ? 1 : 0;
      3'd3: r = (a < b) ? 1 : 0;
      3'd4: r = a ^ b;
      3'd5: r = fn7[5] ? (as >>> sh) : (a / (2 ** sh));
      3'd6: r = a | b;
      default: r = a & b;
    endcase
    r  = r & 15;
    rr = r[3:0];
    return {rr, rr == 4'd0, rr[3], c, v};
  endfunction

  task automatic apply(input logic [2:0] fn3, input logic [6:0] fn7,
                       input logic [3:0] a, input logic [3:0] b);
    f3 = fn3; f7 = fn7; op1 = a; op2 = b;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    f3 = 3'd0; f7 = 7'd0; op1 = 4'b0111; op2 = 4'b0001;
    repeat (2) begin
      @(posedge clk); #1;
      tests++;
      if ({res, zero, neg, carry, ovf} !== 8'h00) begin
        fails++;
        $display("FAIL reset_outputs got=%b want=%b", {res, zero, neg, carry, ovf}, 8'h00);
      end
    end
    rst = 1'b0;
    @(posedge clk); #1;
    tests++;
    if ({res, zero, neg, carry, ovf} !== 8'b1000_0101) begin
      fails++;
      $display("FAIL first_after_reset got=%b want=%b", {res, zero, neg, carry, ovf}, 8'b1000_0101);
    end
  endtask

  // Expected values from the test plan, written as constants: {res, zero, neg, carry, ovf}.
  task automatic test_directed;
    logic [2:0] t3[19];
    logic [6:0] t7[19];
    logic [3:0] ta[19], tb[19];
    logic [7:0] te[19];
    t3 = '{0,0,0,0,0,0,0,0,0,0,5,5,1,2,3,1,5,0,4};
    t7 = '{7'h20,7'h20,7'h20,7'h20,7'h20,7'h20,7'h20,7'h20,7'h00,7'h00,
           7'h20,7'h00,7'h00,7'h00,7'h00,7'h00,7'h20,7'h5F,7'h20};
    ta = '{4'hF,4'h8,4'hD,4'h7,4'h6,4'h1,4'hB,4'h4,4'h7,4'hF,4'h8,4'h8,4'h3,4'hF,4'hF,4'hB,4'hB,4'h2,4'hC};
    tb = '{4'h8,4'hF,4'h6,4'hD,4'h5,4'h4,4'hB,4'h4,4'h1,4'h1,4'h3,4'h3,4'h2,4'h1,4'h1,4'h4,4'h4,4'h3,4'hA};
    te = '{8'b0111_0000, 8'b1001_0110, 8'b0111_0001, 8'b1010_0111, 8'b0001_0000,
           8'b1101_0110, 8'b0000_1000, 8'b0000_1000, 8'b1000_0101, 8'b0000_1010,
           8'b1111_0100, 8'b0001_0000, 8'b1100_0100, 8'b0001_0000, 8'b0000_1000,
           8'b1011_0100, 8'b1011_0100, 8'b0101_0000, 8'b0110_0000};
    for (int i = 0; i < 19; i++) begin
      apply(t3[i], t7[i], ta[i], tb[i]);
      tests++;
      if ({res, zero, neg, carry, ovf} !== te[i]) begin
        fails++;
        $display("FAIL directed_%0d f3=%0d a=%b b=%b got=%b want=%b",
                 i, t3[i], ta[i], tb[i], {res, zero, neg, carry, ovf}, te[i]);
      end
    end
  endtask

  // Back-to-back random ops, one per cycle, with arbitrary funct7 bits.
  task automatic test_back_to_back;
    logic [2:0] fn3;
    logic [6:0] fn7;
    logic [3:0] a, b;
    logic [7:0] exp_v;
    for (int i = 0; i < 400; i++) begin
      fn3 = 3'($urandom_range(0, 7));
      fn7 = 7'($urandom_range(0, 127));
      a   = 4'($urandom_range(0, 15));
      b   = 4'($urandom_range(0, 15));
      exp_v = model(fn3, fn7, int'(a), int'(b));
      apply(fn3, fn7, a, b);
      tests++;
      if ({res, zero, neg, carry, ovf} !== exp_v) begin
        fails++;
        $display("FAIL random_%0d f3=%0d f7=%b a=%b b=%b got=%b want=%b",
                 i, fn3, fn7, a, b, {res, zero, neg, carry, ovf}, exp_v);
      end
    end
  endtask

  // Reset arriving mid-stream drops the operation presented in that cycle.
  task automatic test_mid_reset;
    apply(3'd0, 7'h00, 4'hF, 4'h1);
    rst = 1'b1;
    apply(3'd0, 7'h20, 4'h1, 4'h4);
    tests++;
    if ({res, zero, neg, carry, ovf} !== 8'h00) begin
      fails++;
      $display("FAIL mid_reset got=%b want=%b", {res, zero, neg, carry, ovf}, 8'h00);
    end
    rst = 1'b0;
    apply(3'd0, 7'h20, 4'h1, 4'h4);
    tests++;
    if ({res, zero, neg, carry, ovf} !== 8'b1101_0110) begin
      fails++;
      $display("FAIL after_mid_reset got=%b want=%b", {res, zero, neg, carry, ovf}, 8'b1101_0110);
    end
  endtask

  initial begin
    rst = 1'b1; f3 = '0; f7 = '0; op1 = '0; op2 = '0;
    #1;
    test_reset;
    test_directed;
    test_back_to_back;
    test_mid_reset;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
